// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, RUN/HALT control and fetch counter.
// Latency: one cycle from imem_a to if_*; stall holds everything, and branch_taken overrides stall.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus8,
    output logic        if_valid,
    output logic        halted,
    output logic        align_err,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  RUN      = 1'b0;
    localparam logic [0:0]  HALT     = 1'b1;
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] fetch_cnt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        pc_in_range;

    assign pc_plus4    = pc + 32'd4;
    assign pc_plus8    = pc + 32'd8;
    assign pc_in_range = (pc < PC_LIMIT);

    assign imem_a      = pc;
    assign halted      = (state == HALT);
    assign fetch_count = fetch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            if_pc_plus8 <= 32'd0;
            if_valid    <= 1'b0;
            align_err   <= 1'b0;
            fetch_cnt   <= 32'd0;
        end else if (branch_taken) begin
            // Redirect wins over stall; the low address bits are dropped but remembered as an error.
            state       <= RUN;
            pc          <= {branch_target[31:2], 2'b00};
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            if_pc_plus8 <= 32'd0;
            if_valid    <= 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end
        end else if (stall) begin
            state <= state;
        end else if (state == HALT) begin
            if_instr <= 32'd0;
            if_valid <= 1'b0;
        end else if (pc_in_range) begin
            pc          <= pc_plus4;
            if_instr    <= imem_rd;
            if_pc       <= pc;
            if_pc_plus8 <= pc_plus8;
            if_valid    <= 1'b1;
            if (fetch_cnt != 32'hFFFF_FFFF) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end else begin
            // Ran off the end of memory: publish the bad PC as a bubble and park here.
            state       <= HALT;
            if_instr    <= 32'd0;
            if_pc       <= pc;
            if_pc_plus8 <= pc_plus8;
            if_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational 64-word instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus8;
    logic        if_valid;
    logic        halted;
    logic        align_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int checks;
    int failures;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_a(imem_a),
        .imem_rd(imem_rd),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .if_pc_plus8(if_pc_plus8),
        .if_valid(if_valid),
        .halted(halted),
        .align_err(align_err),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rd = (imem_a < 32'd256) ? mem[imem_a[7:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'hE3A0_000A;
        mem[1] = 32'hE3A0_1005;
        mem[2] = 32'hE080_0001;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus8", if_pc_plus8, 32'd0);
        chk("rst_imem_a", imem_a, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);

        // Straight-line fetch of three words
        reset = 1'b0;
        step();
        chk("seq0_instr", if_instr, 32'hE3A0_000A);
        chk("seq0_pc", if_pc, 32'd0);
        chk("seq0_pc8", if_pc_plus8, 32'd8);
        chk("seq0_valid", {31'd0, if_valid}, 32'd1);
        chk("seq0_imem_a", imem_a, 32'd4);
        step();
        chk("seq1_instr", if_instr, 32'hE3A0_1005);
        chk("seq1_pc", if_pc, 32'd4);
        chk("seq1_pc8", if_pc_plus8, 32'd12);
        step();
        chk("seq2_instr", if_instr, 32'hE080_0001);
        chk("seq2_pc", if_pc, 32'd8);
        chk("seq2_pc8", if_pc_plus8, 32'd16);
        chk("seq2_count", fetch_count, 32'd3);

        // Two-cycle stall after the first fetch
        do_reset();
        step();
        chk("stl_pre_count", fetch_count, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stl_instr", if_instr, 32'hE3A0_000A);
            chk("stl_imem_a", imem_a, 32'd4);
            chk("stl_count", fetch_count, 32'd1);
            chk("stl_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk("stl_rel_instr", if_instr, 32'hE3A0_1005);
        chk("stl_rel_count", fetch_count, 32'd2);
        chk("stl_rel_imem_a", imem_a, 32'd8);

        // Branch together with stall at PC=4
        do_reset();
        step();
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h8;
        step();
        stall = 1'b0;
        branch_taken = 1'b0;
        chk("br_valid", {31'd0, if_valid}, 32'd0);
        chk("br_instr", if_instr, 32'd0);
        chk("br_pc", if_pc, 32'd0);
        chk("br_imem_a", imem_a, 32'd8);
        chk("br_count", fetch_count, 32'd1);
        step();
        chk("br_tgt_instr", if_instr, 32'hE080_0001);
        chk("br_tgt_pc", if_pc, 32'd8);
        chk("br_tgt_count", fetch_count, 32'd2);

        // Misaligned target and sticky align_err
        branch_taken = 1'b1;
        branch_target = 32'hFE;
        step();
        chk("mis_imem_a", imem_a, 32'hFC);
        chk("mis_align", {31'd0, align_err}, 32'd1);
        branch_target = 32'h0;
        step();
        branch_taken = 1'b0;
        chk("mis_sticky_br", {31'd0, align_err}, 32'd1);
        chk("mis_imem_a0", imem_a, 32'd0);
        step();
        chk("mis_sticky_run", {31'd0, align_err}, 32'd1);
        chk("mis_run_instr", if_instr, 32'hE3A0_000A);
        do_reset();
        chk("mis_clr_reset", {31'd0, align_err}, 32'd0);

        // Run off the end of memory into HALT, then branch back
        branch_taken = 1'b1;
        branch_target = 32'hF8;
        step();
        branch_taken = 1'b0;
        step();
        chk("end_f8_instr", if_instr, 32'hA000_003E);
        step();
        chk("end_fc_instr", if_instr, 32'hA000_003F);
        chk("end_imem_a", imem_a, 32'h100);
        step();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, if_valid}, 32'd0);
        chk("halt_instr", if_instr, 32'd0);
        chk("halt_pc", if_pc, 32'h100);
        chk("halt_pc8", if_pc_plus8, 32'h108);
        chk("halt_imem_a", imem_a, 32'h100);
        chk("halt_count", fetch_count, 32'd2);
        step();
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        chk("halt2_imem_a", imem_a, 32'h100);
        chk("halt2_count", fetch_count, 32'd2);
        branch_taken = 1'b1;
        branch_target = 32'h0;
        step();
        branch_taken = 1'b0;
        chk("unhalt_halted", {31'd0, halted}, 32'd0);
        chk("unhalt_valid", {31'd0, if_valid}, 32'd0);
        chk("unhalt_imem_a", imem_a, 32'd0);
        step();
        chk("unhalt_instr", if_instr, 32'hE3A0_000A);

        // PC+8 wraps modulo 2^32
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        step();
        chk("wrap_halted", {31'd0, halted}, 32'd1);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc8", if_pc_plus8, 32'h0000_0004);

        // Reset overrides branch and stall while halted
        reset = 1'b1;
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h13;
        step();
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        chk("ovr_imem_a", imem_a, 32'd0);
        chk("ovr_halted", {31'd0, halted}, 32'd0);
        chk("ovr_align", {31'd0, align_err}, 32'd0);
        chk("ovr_count", fetch_count, 32'd0);

        // Saturating fetch counter
        stall = 1'b1;
        step();
        force dut.fetch_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_cnt;
        @(negedge clk);
        stall = 1'b0;
        step();
        chk("sat_to_max", fetch_count, 32'hFFFF_FFFF);
        step();
        chk("sat_hold", fetch_count, 32'hFFFF_FFFF);
        chk("sat_instr", if_instr, 32'hE3A0_1005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words; valid byte range is 0 to 4*IMEM_WORDS-1.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 Port branch_taken  input  1  redirect the PC to branch_target this cycle.
REQ-007 Port branch_target  input  32  byte address of the redirect.
REQ-008 Port imem_a  output  32  byte address driven to the instruction memory.
REQ-009 Port imem_rd  input  32  combinational read data returned for imem_a in the same cycle.
REQ-010 Port if_instr  output  32  registered instruction handed to decode.
REQ-011 Port if_pc  output  32  registered address of if_instr.
REQ-012 Port if_pc_plus8  output  32  registered if_pc+8, the architectural PC read value.
REQ-013 Port if_valid  output  1  if_instr holds a real fetched instruction.
REQ-014 Port halted  output  1  fetch state is HALT.
REQ-015 Port align_err  output  1  sticky flag: a branch_target with bits [1:0] != 0 was accepted.
REQ-016 Port fetch_count  output  32  number of valid instructions captured, saturating.

Function
REQ-017 imem_a SHALL equal the PC register combinationally, with zero added latency.
REQ-018 State machine SHALL have two states: RUN and HALT; halted = (state == HALT).
REQ-019 Per-cycle priority SHALL be reset > branch_taken > stall > normal advance.
REQ-020 Normal advance (RUN, no branch, no stall, PC < 4*IMEM_WORDS): IF/ID loads {imem_rd, PC, PC+8, valid=1}; PC <= PC+4.
REQ-021 Out of range (RUN, no branch, no stall, PC >= 4*IMEM_WORDS): IF/ID loads {0, PC, PC+8, valid=0}; PC is held; state goes to HALT.
REQ-022 Branch: PC <= {branch_target[31:2], 2'b00}; IF/ID is flushed to {0, 0, 0, valid=0}; state goes to RUN; stall is ignored.
REQ-023 A branch whose target has bits [1:0] != 0 SHALL set align_err to 1; align_err is cleared only by reset.
REQ-024 Stall without branch: PC, IF/ID, state and fetch_count SHALL all hold their values.
REQ-025 HALT with no branch: PC holds, if_valid = 0, if_instr = 0; only branch_taken or reset leaves HALT.
REQ-026 fetch_count SHALL increment by 1 on every cycle that loads valid=1; it saturates at 32'hFFFF_FFFF, with no wrap.
REQ-027 PC+4 and PC+8 SHALL be 32-bit modulo sums; no carry-out is kept.
REQ-028 if_* outputs SHALL be registered only; no combinational path from imem_rd to if_instr.

Reset
REQ-029 On reset the block SHALL set: PC = RESET_PC; if_instr = 0; if_pc = 0; if_pc_plus8 = 0; if_valid = 0; state = RUN; align_err = 0; fetch_count = 0.
REQ-030 Reset asserted mid-stall, mid-branch or in HALT SHALL override all other inputs in that cycle.
REQ-031 The first valid instruction SHALL appear on if_* one cycle after reset deasserts, given no stall.

Verification
REQ-032 Memory holds 0xE3A0000A, 0xE3A01005, 0xE0800001 at byte addresses 0, 4, 8; reset, then run 3 cycles -> if_instr sequence 0xE3A0000A, 0xE3A01005, 0xE0800001; if_pc 0, 4, 8; if_pc_plus8 8, 12, 16; fetch_count 3.
REQ-033 Stall held for 2 cycles after the first fetch -> if_instr stays 0xE3A0000A, imem_a stays 4, fetch_count stays 1; the next fetch after release yields 0xE3A01005.
REQ-034 branch_taken=1 with target 0x8, asserted together with stall=1, at PC=4 -> next cycle if_valid=0 and imem_a=8; the cycle after, if_instr=0xE0800001.
REQ-035 Branch target 0xFE (IMEM_WORDS=64) -> imem_a=0xFC; align_err=1 and stays 1 through later branches until reset.
REQ-036 PC reaches 0x100 -> halted=1, if_valid=0, imem_a holds 0x100; a branch to 0x0 clears halted, and if_instr=0xE3A0000A two cycles later.
REQ-037 Preload fetch_count to 0xFFFF_FFFF and fetch once more -> fetch_count stays 0xFFFF_FFFF.
